vga_pmod_bridge: RTL



---
 rtl/vga_pmod_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_pmod_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vga_pmod_bridge
// Purpose  : PMOD VGA receiver with resync, per-frame colour mode and link watchdog
// Revision : 1.0
// ============================================================================
module vga_pmod_bridge #(
    parameter int          PIX_W       = 1,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT_CYC = 4_000_000,
    parameter logic [11:0] FG_COLOR    = 12'h0F0,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter int          BAR_SHIFT   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic [1:0]       colour_sel,
    output logic [11:0]      vga_out,
    output logic             h_sync_out,
    output logic             v_sync_out,
    output logic             led_h,
    output logic             led_v,
    output logic             led_link,
    output logic [7:0]       led_frame
);

    localparam int                c_in_w   = PIX_W + 4;
    localparam int                c_wd_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_CYC);

    localparam logic [1:0] c_link_down = 2'd0;
    localparam logic [1:0] c_link_acq  = 2'd1;
    localparam logic [1:0] c_link_up   = 2'd2;

    logic [c_in_w-1:0] r_sync [SYNC_STAGES];
    logic [PIX_W-1:0]  w_p_s;
    logic              w_h_s;
    logic              w_v_s;
    logic [1:0]        w_c_s;
    logic              r_h_d;
    logic              r_v_d;
    logic              w_h_rise;
    logic              w_v_rise;
    logic [1:0]        r_mode;
    logic [11:0]       r_hcnt;
    logic [2:0]        w_bar;
    logic [3:0]        w_int;
    logic [11:0]       w_colour;
    logic [11:0]       r_vga;
    logic [c_wd_w-1:0] r_wd;
    logic              w_timeout;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_frame;

    // All asynchronous inputs share one synchroniser chain so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= {colour_sel, v_sync_in, h_sync_in, pix_in};
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_p_s    = r_sync[SYNC_STAGES-1][PIX_W-1:0];
    assign w_h_s    = r_sync[SYNC_STAGES-1][PIX_W];
    assign w_v_s    = r_sync[SYNC_STAGES-1][PIX_W+1];
    assign w_c_s    = r_sync[SYNC_STAGES-1][PIX_W+3:PIX_W+2];
    assign w_h_rise = w_h_s & ~r_h_d;
    assign w_v_rise = w_v_s & ~r_v_d;

    generate
        if (PIX_W == 1) begin : g_int_w1
            assign w_int = {4{w_p_s[0]}};
        end else if (PIX_W == 2) begin : g_int_w2
            assign w_int = {w_p_s, w_p_s};
        end else if (PIX_W == 3) begin : g_int_w3
            assign w_int = {w_p_s, w_p_s[2]};
        end else begin : g_int_w4
            assign w_int = w_p_s[3:0];
        end
    endgenerate

    assign w_bar = r_hcnt[BAR_SHIFT+2:BAR_SHIFT];

    always_comb begin
        w_colour = BG_COLOR;
        case (r_mode)
            2'd0:    w_colour = (w_p_s != '0) ? FG_COLOR : BG_COLOR;
            2'd1:    w_colour = {w_int, w_int, w_int};
            2'd2:    w_colour = {4'h0, w_int, 4'h0};
            default: w_colour = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
        endcase
    end

    // A V-sync rise in the saturation cycle counts as a live link.
    assign w_timeout = (r_wd == c_wd_max) & ~w_v_rise;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_link_down: if (w_v_rise) w_state_nxt = c_link_acq;
            c_link_acq: begin
                if (w_v_rise)       w_state_nxt = c_link_up;
                else if (w_timeout) w_state_nxt = c_link_down;
            end
            c_link_up:   if (w_timeout) w_state_nxt = c_link_down;
            default:     w_state_nxt = c_link_down;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_d   <= 1'b0;
            r_v_d   <= 1'b0;
            r_mode  <= 2'd2;
            r_hcnt  <= '0;
            r_wd    <= '0;
            r_state <= c_link_down;
            r_frame <= '0;
            r_vga   <= '0;
        end else begin
            r_h_d   <= w_h_s;
            r_v_d   <= w_v_s;
            r_state <= w_state_nxt;
            r_vga   <= (r_state == c_link_up) ? w_colour : 12'h000;

            if (w_v_rise) r_mode <= w_c_s;

            if (w_h_rise)                r_hcnt <= '0;
            else if (r_hcnt != 12'hFFF)  r_hcnt <= r_hcnt + 12'd1;

            if (w_v_rise)                r_wd <= '0;
            else if (r_wd != c_wd_max)   r_wd <= r_wd + c_wd_w'(1);

            if (w_state_nxt == c_link_down)
                r_frame <= '0;
            else if (r_state == c_link_up && w_v_rise)
                r_frame <= r_frame + 8'd1;
        end
    end

    // The edge-detect delay registers double as the sync output stage, keeping
    // syncs one clock behind the synchronisers exactly like the colour register.
    assign vga_out    = r_vga;
    assign h_sync_out = r_h_d;
    assign v_sync_out = r_v_d;
    assign led_h      = w_h_s;
    assign led_v      = w_v_s;
    assign led_link   = (r_state == c_link_up);
    assign led_frame  = r_frame;

endmodule
`default_nettype wire
